// File: rtl/commit_trace_buf.sv
// commit_trace_buf: retirement-record buffer between the commit point and the
// trace consumer. Classifies each committed instruction, numbers it, queues it
// in a DEPTH-entry FIFO drained by valid/ready, and sequences the halt drain
// (RUN -> DRAIN -> DONE).
// Optional build macro: TRACE_FILTER_NOP_EN -- when defined, kind-0 (NOP/branch)
// commits consume an instruction number but are not queued and never overflow.
module commit_trace_buf #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        commit_valid,
   input  logic [15:0] commit_pc,
   input  logic        commit_reg_wr,
   input  logic [2:0]  commit_wr_reg,
   input  logic [15:0] commit_wr_data,
   input  logic        commit_mem_rd,
   input  logic        commit_mem_wr,
   input  logic [15:0] commit_mem_addr,
   input  logic [15:0] commit_mem_data,
   input  logic        commit_halt,
   output logic        stall_req,
   output logic        rec_valid,
   input  logic        rec_ready,
   output logic [2:0]  rec_kind,
   output logic [15:0] rec_inum,
   output logic [15:0] rec_pc,
   output logic [2:0]  rec_reg,
   output logic [15:0] rec_reg_data,
   output logic [15:0] rec_addr,
   output logic [15:0] rec_data,
   output logic [31:0] cycle_count,
   output logic [15:0] inst_count,
   output logic        halted,
   output logic        overflow
);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic [2:0]  kind;
      logic [15:0] inum;
      logic [15:0] pc;
      logic [2:0]  wreg;
      logic [15:0] wdata;
      logic [15:0] addr;
      logic [15:0] sdata;
   } rec_t;

   localparam logic [2:0]     K_NOP   = 3'd0;
   localparam logic [2:0]     K_REG   = 3'd1;
   localparam logic [2:0]     K_LOAD  = 3'd2;
   localparam logic [2:0]     K_STORE = 3'd3;
   localparam logic [2:0]     K_STU   = 3'd4;
   localparam logic [2:0]     K_HALT  = 3'd5;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   state_t           state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [31:0]      cycle_q, cycle_d;
   logic [15:0]      inst_q, inst_d;
   logic             ovf_q, ovf_d;
   rec_t             mem_q [DEPTH];

   logic [2:0] kind;
   rec_t       new_rec;
   rec_t       head;
   logic       full, in_run, pop, filt, take, push, drop;

   // Classify the retiring instruction and build its record, zeroing unused fields
   always_comb begin
      kind = K_NOP;
      if (commit_halt)                        kind = K_HALT;
      else if (commit_reg_wr && commit_mem_wr) kind = K_STU;
      else if (commit_reg_wr && commit_mem_rd) kind = K_LOAD;
      else if (commit_reg_wr)                 kind = K_REG;
      else if (commit_mem_wr)                 kind = K_STORE;

      new_rec      = '0;
      new_rec.kind = kind;
      new_rec.inum = inst_q;
      new_rec.pc   = commit_pc;
      if (kind == K_REG || kind == K_LOAD || kind == K_STU) begin
         new_rec.wreg  = commit_wr_reg;
         new_rec.wdata = commit_wr_data;
      end
      if (kind == K_LOAD || kind == K_STORE || kind == K_STU)
         new_rec.addr = commit_mem_addr;
      if (kind == K_STORE || kind == K_STU)
         new_rec.sdata = commit_mem_data;
   end

   // Push/pop/drop decisions; a pop frees a slot for a same-cycle push at full
   always_comb begin
      full   = (count_q == FULL_CNT);
      in_run = (state_q == S_RUN);
      pop    = (count_q != '0) && rec_ready;
`ifdef TRACE_FILTER_NOP_EN
      filt   = (kind == K_NOP);
`else
      filt   = 1'b0;
`endif
      take   = commit_valid && in_run && (filt || !full || pop);
      push   = take && !filt;
      drop   = commit_valid && in_run && !filt && full && !pop;
   end

   // Next-state for FIFO pointers, counters, sticky overflow and the halt sequencer
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      cycle_d  = cycle_q;
      inst_d   = inst_q;
      ovf_d    = ovf_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (take) inst_d = inst_q + 16'd1;
      if (drop) ovf_d = 1'b1;
      if (state_q != S_DONE) cycle_d = cycle_q + 32'd1;

      case (state_q)
         S_RUN:   if (push && kind == K_HALT) state_d = S_DRAIN;
         S_DRAIN: if (pop && count_q == 1 && head.kind == K_HALT) state_d = S_DONE;
         S_DONE:  state_d = S_DONE;
         default: state_d = S_RUN;
      endcase
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_RUN;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cycle_q  <= '0;
         inst_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         cycle_q  <= cycle_d;
         inst_q   <= inst_d;
         ovf_q    <= ovf_d;
      end
   end

   // Record storage; contents are only observable through a valid head
   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q] <= new_rec;
   end

   // Head record and status outputs; fields read as 0 while the FIFO is empty
   always_comb begin
      head         = mem_q[rd_ptr_q];
      rec_valid    = (count_q != '0);
      rec_kind     = '0;
      rec_inum     = '0;
      rec_pc       = '0;
      rec_reg      = '0;
      rec_reg_data = '0;
      rec_addr     = '0;
      rec_data     = '0;
      if (rec_valid) begin
         rec_kind     = head.kind;
         rec_inum     = head.inum;
         rec_pc       = head.pc;
         rec_reg      = head.wreg;
         rec_reg_data = head.wdata;
         rec_addr     = head.addr;
         rec_data     = head.sdata;
      end
      stall_req   = in_run && full && !pop;
      cycle_count = cycle_q;
      inst_count  = inst_q;
      halted      = (state_q == S_DONE);
      overflow    = ovf_q;
   end

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed bench for commit_trace_buf (default build, DEPTH=8).
module tb_commit_trace_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        commit_valid;
   logic [15:0] commit_pc;
   logic        commit_reg_wr;
   logic [2:0]  commit_wr_reg;
   logic [15:0] commit_wr_data;
   logic        commit_mem_rd;
   logic        commit_mem_wr;
   logic [15:0] commit_mem_addr;
   logic [15:0] commit_mem_data;
   logic        commit_halt;
   logic        stall_req;
   logic        rec_valid;
   logic        rec_ready;
   logic [2:0]  rec_kind;
   logic [15:0] rec_inum;
   logic [15:0] rec_pc;
   logic [2:0]  rec_reg;
   logic [15:0] rec_reg_data;
   logic [15:0] rec_addr;
   logic [15:0] rec_data;
   logic [31:0] cycle_count;
   logic [15:0] inst_count;
   logic        halted;
   logic        overflow;

   int errors = 0;
   int checks = 0;

   commit_trace_buf #(.DEPTH(8), .PTR_W(3)) dut (
      .clk(clk), .rst(rst),
      .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_reg_wr(commit_reg_wr), .commit_wr_reg(commit_wr_reg),
      .commit_wr_data(commit_wr_data), .commit_mem_rd(commit_mem_rd),
      .commit_mem_wr(commit_mem_wr), .commit_mem_addr(commit_mem_addr),
      .commit_mem_data(commit_mem_data), .commit_halt(commit_halt),
      .stall_req(stall_req), .rec_valid(rec_valid), .rec_ready(rec_ready),
      .rec_kind(rec_kind), .rec_inum(rec_inum), .rec_pc(rec_pc),
      .rec_reg(rec_reg), .rec_reg_data(rec_reg_data), .rec_addr(rec_addr),
      .rec_data(rec_data), .cycle_count(cycle_count), .inst_count(inst_count),
      .halted(halted), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      commit_valid    = 1'b0;
      commit_pc       = '0;
      commit_reg_wr   = 1'b0;
      commit_wr_reg   = '0;
      commit_wr_data  = '0;
      commit_mem_rd   = 1'b0;
      commit_mem_wr   = 1'b0;
      commit_mem_addr = '0;
      commit_mem_data = '0;
      commit_halt     = 1'b0;
   endtask

   task automatic commit(input logic [15:0] pc, input logic rw, input logic [2:0] rg,
                         input logic [15:0] wd, input logic mr, input logic mw,
                         input logic [15:0] ad, input logic [15:0] md, input logic h);
      commit_valid    = 1'b1;
      commit_pc       = pc;
      commit_reg_wr   = rw;
      commit_wr_reg   = rg;
      commit_wr_data  = wd;
      commit_mem_rd   = mr;
      commit_mem_wr   = mw;
      commit_mem_addr = ad;
      commit_mem_data = md;
      commit_halt     = h;
   endtask

   task automatic do_reset();
      idle();
      rec_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      idle();
      rec_ready = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      // Reset state
      chk("rst_rec_valid", 32'(rec_valid), 0);
      chk("rst_kind", 32'(rec_kind), 0);
      chk("rst_cycle", cycle_count, 0);
      chk("rst_inst", 32'(inst_count), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_stall", 32'(stall_req), 0);

      // Single ALU commit, visible one cycle later
      rec_ready = 1'b1;
      commit(16'h0000, 1, 3'd3, 16'h1234, 0, 0, 16'h0, 16'h0, 0);
      step();
      idle();
      chk("alu_valid", 32'(rec_valid), 1);
      chk("alu_kind", 32'(rec_kind), 1);
      chk("alu_inum", 32'(rec_inum), 0);
      chk("alu_reg", 32'(rec_reg), 3);
      chk("alu_reg_data", 32'(rec_reg_data), 32'h1234);
      chk("alu_addr", 32'(rec_addr), 0);
      chk("alu_inst", 32'(inst_count), 1);
      step();
      chk("alu_popped", 32'(rec_valid), 0);
      chk("alu_cycle", cycle_count, 2);

      // Load then store-with-update back to back
      do_reset();
      commit(16'h0002, 1, 3'd5, 16'h00AA, 1, 0, 16'h0040, 16'h0, 0);
      step();
      commit(16'h0004, 1, 3'd6, 16'h0044, 0, 1, 16'h0042, 16'hBEEF, 0);
      step();
      idle();
      chk("ld_kind", 32'(rec_kind), 2);
      chk("ld_inum", 32'(rec_inum), 0);
      chk("ld_addr", 32'(rec_addr), 32'h0040);
      chk("ld_reg", 32'(rec_reg), 5);
      chk("ld_data_zero", 32'(rec_data), 0);
      step();
      chk("ld_held", 32'(rec_kind), 2);
      rec_ready = 1'b1;
      step();
      chk("stu_kind", 32'(rec_kind), 4);
      chk("stu_inum", 32'(rec_inum), 1);
      chk("stu_addr", 32'(rec_addr), 32'h0042);
      chk("stu_data", 32'(rec_data), 32'hBEEF);
      chk("stu_reg_data", 32'(rec_reg_data), 32'h0044);
      step();
      chk("stu_empty", 32'(rec_valid), 0);

      // Fill to full, then overflow, then drain in order
      do_reset();
      for (int i = 0; i < 8; i++) begin
         commit(16'(2 * i), 1, 3'd1, 16'(i), 0, 0, 16'h0, 16'h0, 0);
         step();
      end
      idle();
      chk("full_stall", 32'(stall_req), 1);
      chk("full_inst", 32'(inst_count), 8);
      commit(16'h0020, 1, 3'd1, 16'h9, 0, 0, 16'h0, 16'h0, 0);
      step();
      idle();
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_inst", 32'(inst_count), 8);
      rec_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_valid", 32'(rec_valid), 1);
         chk("drain_inum", 32'(rec_inum), 32'(i));
         step();
      end
      chk("drain_empty", 32'(rec_valid), 0);
      chk("ovf_sticky", 32'(overflow), 1);

      // Push and pop together at full
      do_reset();
      for (int i = 0; i < 8; i++) begin
         commit(16'(2 * i), 1, 3'd2, 16'(i), 0, 0, 16'h0, 16'h0, 0);
         step();
      end
      commit(16'h0100, 1, 3'd2, 16'h77, 0, 0, 16'h0, 16'h0, 0);
      rec_ready = 1'b1;
      #1;
      chk("pp_stall_low", 32'(stall_req), 0);
      step();
      idle();
      rec_ready = 1'b0;
      #1;
      chk("pp_still_full", 32'(stall_req), 1);
      chk("pp_ovf", 32'(overflow), 0);
      chk("pp_inst", 32'(inst_count), 9);
      chk("pp_head", 32'(rec_inum), 1);
      rec_ready = 1'b1;
      for (int i = 1; i < 8; i++) step();
      chk("pp_last_inum", 32'(rec_inum), 8);
      chk("pp_last_pc", 32'(rec_pc), 32'h0100);
      step();
      chk("pp_empty", 32'(rec_valid), 0);

      // Halt behind two stores; drain sequencing and frozen cycle counter
      do_reset();
      commit(16'h0008, 0, 3'd0, 16'h0, 0, 1, 16'h0020, 16'h1111, 0);
      step();
      commit(16'h000A, 0, 3'd0, 16'h0, 0, 1, 16'h0022, 16'h2222, 0);
      step();
      commit(16'h0010, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
      step();
      commit(16'h0012, 1, 3'd4, 16'h5555, 0, 0, 16'h0, 16'h0, 0);
      step();
      chk("drain_ignore_inst", 32'(inst_count), 3);
      chk("drain_stall", 32'(stall_req), 0);
      rec_ready = 1'b1;
      chk("st1_kind", 32'(rec_kind), 3);
      chk("st1_data", 32'(rec_data), 32'h1111);
      chk("st1_reg_zero", 32'(rec_reg_data), 0);
      step();
      chk("st2_kind", 32'(rec_kind), 3);
      chk("st2_addr", 32'(rec_addr), 32'h0022);
      step();
      chk("halt_kind", 32'(rec_kind), 5);
      chk("halt_pc", 32'(rec_pc), 32'h0010);
      chk("halt_inum", 32'(rec_inum), 2);
      chk("halt_not_yet", 32'(halted), 0);
      step();
      chk("halted", 32'(halted), 1);
      chk("done_empty", 32'(rec_valid), 0);
      chk("done_cycle", cycle_count, 7);
      step();
      step();
      step();
      chk("done_cycle_frozen", cycle_count, 7);
      chk("done_inst", 32'(inst_count), 3);
      chk("done_stall", 32'(stall_req), 0);
      chk("done_halted_hold", 32'(halted), 1);
      idle();

      // Reset during drain with three records queued
      do_reset();
      commit(16'h0030, 1, 3'd1, 16'h1, 0, 0, 16'h0, 16'h0, 0);
      step();
      commit(16'h0032, 1, 3'd2, 16'h2, 0, 0, 16'h0, 16'h0, 0);
      step();
      commit(16'h0034, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
      step();
      idle();
      chk("pre_rst_valid", 32'(rec_valid), 1);
      chk("pre_rst_inst", 32'(inst_count), 3);
      do_reset();
      chk("mid_rst_valid", 32'(rec_valid), 0);
      chk("mid_rst_cycle", cycle_count, 0);
      chk("mid_rst_inst", 32'(inst_count), 0);
      chk("mid_rst_halted", 32'(halted), 0);
      chk("mid_rst_ovf", 32'(overflow), 0);
      commit(16'h0040, 1, 3'd7, 16'hABCD, 0, 0, 16'h0, 16'h0, 0);
      step();
      idle();
      chk("run_after_rst_valid", 32'(rec_valid), 1);
      chk("run_after_rst_inum", 32'(rec_inum), 0);
      chk("run_after_rst_data", 32'(rec_reg_data), 32'hABCD);
      chk("run_after_rst_inst", 32'(inst_count), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the run can never hang
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/commit_trace_buf.md
Name: commit_trace_buf

Overview:
- Synthesizable retirement-record buffer between the processor's writeback/commit point and the simulation trace/log consumer.
- Each cycle it classifies the committed instruction:
  - NOP/branch
  - register write
  - load
  - store
  - store-with-update
  - halt
- Numbers each committed instruction and queues the record in a FIFO that the consumer drains with a valid/ready handshake.
- Keeps cycle and instruction counters and sequences the halt drain, so the trace is emitted in order and no record is lost.

Parameters:
- DEPTH, 8, FIFO entries (power of two, at least 2)
- PTR_W, 3, log2(DEPTH)

Ports:
- clk  input  1  processor clock
- rst  input  1  synchronous, active-high reset
- commit_valid  input  1  an instruction retires this cycle
- commit_pc  input  16  byte PC of the retiring instruction
- commit_reg_wr  input  1  register file written
- commit_wr_reg  input  3  destination register
- commit_wr_data  input  16  register write data
- commit_mem_rd  input  1  data memory read
- commit_mem_wr  input  1  data memory write
- commit_mem_addr  input  16  memory address
- commit_mem_data  input  16  store data
- commit_halt  input  1  retiring instruction is HALT
- stall_req  output  1  buffer cannot accept a commit; asserted when full and no pop this cycle
- rec_valid  output  1  head record available
- rec_ready  input  1  consumer accepts the head record
- rec_kind  output  3  0 NOP/branch, 1 reg-write, 2 load, 3 store, 4 store-update, 5 halt
- rec_inum  output  16  instruction number
- rec_pc  output  16  PC
- rec_reg  output  3  destination register
- rec_reg_data  output  16  register write data
- rec_addr  output  16  memory address
- rec_data  output  16  store data
- cycle_count  output  32  cycles since reset
- inst_count  output  16  accepted commits
- halted  output  1  halt record drained
- overflow  output  1  sticky: a commit was dropped

Behaviour:
- Reset (clk edge with rst=1): all outputs 0, FIFO empty, state RUN. Reset mid-drain discards all queued records.
- Kind classification, priority order:
  - halt → 5
  - reg_wr & mem_wr → 4
  - reg_wr & mem_rd → 2
  - reg_wr → 1
  - mem_wr → 3
  - otherwise → 0
- Unused record fields for a kind are stored as 0.
- Push: commit_valid in state RUN and (not full, or pop in the same cycle).
  - rec_inum = inst_count before the increment.
  - inst_count increments by 1, wrapping at 16 bits.
- Pop: rec_valid & rec_ready.
  - Head fields are registered FIFO outputs, valid whenever rec_valid=1.
  - Head fields are held stable while rec_valid=1 and rec_ready=0.
- Full with no pop: a commit_valid is dropped, overflow is set and held until rst, and inst_count is unchanged.
- Simultaneous push and pop at full: both occur and occupancy is unchanged.
- Simultaneous push and pop at empty: the record becomes visible the next cycle; there is no bypass and latency is 1 cycle.
- cycle_count increments every cycle in RUN and DRAIN and freezes in DONE; it wraps at 32 bits.
- State machine:
  - RUN: a push with kind 5 → DRAIN.
  - DRAIN: commits are ignored (no push, no overflow). When the FIFO becomes empty via the pop of the halt record → DONE.
  - DONE: halted=1 and stall_req=0. All inputs are ignored until rst.
- stall_req = full & ~(rec_valid & rec_ready), in RUN only.

Optional Feature:
- Macro: TRACE_FILTER_NOP_EN.
- Defined:
  - Kind-0 commits are not pushed, but still consume an instruction number (inst_count increments).
  - Kind-0 commits never cause overflow.
- Undefined: kind-0 commits are queued like every other kind.

Test Plan:
- Reset, then ALU commit (pc=0x0000, reg_wr, reg=3, data=0x1234) with rec_ready=1 → one cycle later rec_valid=1, kind=1, inum=0, reg=3, reg_data=0x1234; inst_count=1.
- Load (reg_wr, mem_rd, addr=0x0040) then stu (reg_wr, mem_wr, addr=0x0042, data=0xBEEF) back to back → kinds 2 and 4, inums 0 and 1, addr and data fields match.
- rec_ready=0 with 8 commits (DEPTH=8) → stall_req=1 after the 8th. A 9th commit → overflow=1 and inst_count stays 8. rec_ready=1 → records pop with inums 0..7 in order.
- Full FIFO with push and pop in the same cycle → occupancy stays 8, overflow stays 0, and the new record gets inum 8.
- Halt at pc=0x0010 behind 2 queued stores → kind 5 record popped last. Commits during DRAIN are ignored. halted=1 the cycle after the halt pop; cycle_count frozen thereafter.
- Assert rst during DRAIN with 3 records queued → next cycle rec_valid=0, counters=0, state RUN, halted=0, overflow=0.
